// File: rtl/pkt_serializer.sv
// pkt_serializer: latches a whole packet of parallel words and replays it as a beat-per-cycle stream
module pkt_serializer #(
    parameter int NUM_WORDS = 24,
    parameter int DW        = 36,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    soft_clr,
    input  logic [NUM_WORDS*DW-1:0] pkt_in_data,
    input  logic                    pkt_in_vld,
    output logic                    pkt_in_rdy,
    output logic [DW-1:0]           out_data,
    output logic                    out_vld,
    output logic                    out_sop,
    output logic                    out_eop,
    input  logic                    out_rdy,
    output logic [CNT_W-1:0]        pkt_cnt,
    output logic [CNT_W-1:0]        abort_cnt
);
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_WORDS*DW-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]        pkt_q, pkt_d, abort_q, abort_d;
    logic                    last, xfer, accept;

    // The only combinational path from out_rdy: it lets the next packet in on the last beat.
    assign last       = idx_q == LAST;
    assign xfer       = state_q == SEND && out_rdy;
    assign pkt_in_rdy = !soft_clr && (state_q == IDLE || (state_q == SEND && last && out_rdy));
    assign accept     = pkt_in_vld && pkt_in_rdy;
    assign out_vld    = state_q == SEND;
    assign out_data   = out_vld ? buf_q[int'(idx_q)*DW +: DW] : '0;
    assign out_sop    = out_vld && idx_q == '0;
    assign out_eop    = out_vld && last;
    assign pkt_cnt    = pkt_q;
    assign abort_cnt  = abort_q;

    // Next state: soft_clr wins; a new packet may be latched on the same cycle as the last beat.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        pkt_d   = pkt_q;
        abort_d = abort_q;
        if (soft_clr) begin
            state_d = IDLE;
            idx_d   = '0;
            abort_d = (state_q == SEND && abort_q != '1) ? abort_q + 1'b1 : abort_q;
        end else begin
            if (xfer && !last) idx_d = idx_q + 1'b1;
            if (xfer && last) begin
                pkt_d   = pkt_q + 1'b1;
                state_d = IDLE;
                idx_d   = '0;
            end
            if (accept) begin
                buf_d   = pkt_in_data;
                idx_d   = '0;
                state_d = SEND;
            end
        end
    end

    // State, beat index, packet buffer and status counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            pkt_q   <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            pkt_q   <= pkt_d;
            abort_q <= abort_d;
        end
    end
endmodule

// File: tb/tb_pkt_serializer.sv
// tb_pkt_serializer: randomized and directed stimulus with a beat scoreboard for pkt_serializer
module tb_pkt_serializer;
    localparam int NW = 24;
    localparam int DW = 36;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    logic             clk = 0, rst_n = 0, soft_clr = 0, pkt_in_vld = 0, out_rdy = 1;
    logic [NW*DW-1:0] pkt_in_data = '0;
    logic             pkt_in_rdy, out_vld, out_sop, out_eop;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    pkt_cnt, abort_cnt;

    logic             s_clr = 0, s_vld = 0, s_ordy = 1;
    logic [2*DW-1:0]  s_data = '0;
    logic             s_rdy, s_ovld, s_sop, s_eop;
    logic [DW-1:0]    s_odata;
    logic [3:0]       s_pkt, s_abort;

    beat_t q[$];
    beat_t mb;
    int    n_cmp = 0, n_err = 0, exp_pkt = 0, exp_abort = 0, rdy_mode = 0, rdy_ph = 0;

    always #5 clk = ~clk;

    pkt_serializer #(.NUM_WORDS(NW), .DW(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
        .pkt_in_data(pkt_in_data), .pkt_in_vld(pkt_in_vld), .pkt_in_rdy(pkt_in_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_sop(out_sop), .out_eop(out_eop),
        .out_rdy(out_rdy), .pkt_cnt(pkt_cnt), .abort_cnt(abort_cnt)
    );

    pkt_serializer #(.NUM_WORDS(2), .DW(DW), .CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .soft_clr(s_clr),
        .pkt_in_data(s_data), .pkt_in_vld(s_vld), .pkt_in_rdy(s_rdy),
        .out_data(s_odata), .out_vld(s_ovld), .out_sop(s_sop), .out_eop(s_eop),
        .out_rdy(s_ordy), .pkt_cnt(s_pkt), .abort_cnt(s_abort)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Downstream ready: steady, the 1,0,0,1 pattern, or random.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_rdy = 1;
        else if (rdy_mode == 1) begin
            out_rdy = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
            rdy_ph++;
        end else out_rdy = 1'($urandom_range(0, 1));
    end

    // Monitor: compare the DUT against the queued packet, then apply this cycle's events.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_pkt   = 0;
            exp_abort = 0;
        end else begin
            chk("out_vld", 64'(out_vld), 64'(q.size() != 0));
            chk("pkt_in_rdy", 64'(pkt_in_rdy),
                64'(!soft_clr && (q.size() == 0 || (q.size() == 1 && out_rdy))));
            chk("pkt_cnt", 64'(pkt_cnt), 64'(CW'(exp_pkt)));
            chk("abort_cnt", 64'(abort_cnt), 64'(exp_abort));
            if (out_vld && q.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(q[0].d));
                chk("out_sop", 64'(out_sop), 64'(q[0].sop));
                chk("out_eop", 64'(out_eop), 64'(q[0].eop));
            end
            if (soft_clr) begin
                if (q.size() != 0 && exp_abort < 65535) exp_abort++;
                q.delete();
            end else begin
                if (out_vld && out_rdy && q.size() != 0) begin
                    mb = q.pop_front();
                    if (mb.eop) exp_pkt++;
                end
                if (pkt_in_vld && pkt_in_rdy)
                    for (int i = 0; i < NW; i++) begin
                        mb.d   = pkt_in_data[i*DW +: DW];
                        mb.sop = i == 0;
                        mb.eop = i == NW - 1;
                        q.push_back(mb);
                    end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a packet and wait for its handshake; returns one step after the accepting edge.
    task automatic send_pkt(input bit rnd, input logic [DW-1:0] base, input bit keep);
        logic [63:0] w;
        bit got = 0;
        for (int i = 0; i < NW; i++) begin
            w = {$urandom(), $urandom()};
            pkt_in_data[i*DW +: DW] = rnd ? w[DW-1:0] : base + DW'(i);
        end
        pkt_in_vld = 1;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            got = pkt_in_rdy;
        end
        if (!got) chk("handshake_timeout", 0, 1);
        tick(1);
        if (!keep) pkt_in_vld = 0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 3000 && q.size() != 0; c++) @(negedge clk);
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 0);
        tick(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        rst_n = 1;
        tick(1);
        chk("reset_rdy", 64'(pkt_in_rdy), 1);
        send_pkt(0, '0, 0);
        chk("single_first_sop", 64'(out_sop), 1);
        wait_drain();
        chk("single_pkt_cnt", 64'(pkt_cnt), 1);
        send_pkt(0, 36'hA00, 1);
        send_pkt(0, 36'hB00, 0);
        wait_drain();
        chk("b2b_pkt_cnt", 64'(pkt_cnt), 3);
        rdy_mode = 1;
        send_pkt(0, 36'hC00, 0);
        wait_drain();
        rdy_mode = 0;
        chk("bp_pkt_cnt", 64'(pkt_cnt), 4);
        send_pkt(0, 36'hD00, 0);
        tick(10);
        chk("clr_at_idx10", 64'(out_data), 64'(36'hD0A));
        soft_clr = 1;
        tick(1);
        soft_clr = 0;
        chk("clr_vld", 64'(out_vld), 0);
        chk("clr_abort", 64'(abort_cnt), 1);
        chk("clr_pkt_cnt", 64'(pkt_cnt), 4);
        send_pkt(0, 36'hE00, 0);
        chk("after_clr_sop", 64'(out_sop), 1);
        chk("after_clr_data", 64'(out_data), 64'(36'hE00));
        wait_drain();
        send_pkt(0, 36'hF00, 0);
        tick(5);
        chk("rst_at_idx5", 64'(out_data), 64'(36'hF05));
        #2 rst_n = 0;
        #1;
        chk("rst_vld", 64'(out_vld), 0);
        chk("rst_sop", 64'(out_sop), 0);
        chk("rst_eop", 64'(out_eop), 0);
        chk("rst_data", 64'(out_data), 0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 0);
        chk("rst_abort", 64'(abort_cnt), 0);
        tick(1);
        rst_n = 1;
        send_pkt(0, 36'h100, 0);
        wait_drain();
        chk("post_rst_pkt_cnt", 64'(pkt_cnt), 1);
        rdy_mode = 2;
        for (int p = 0; p < 30; p++) begin
            send_pkt(1, '0, 0);
            if ($urandom_range(0, 4) == 0) begin
                tick($urandom_range(0, 30));
                soft_clr = 1;
                tick(1);
                soft_clr = 0;
            end
            tick($urandom_range(0, 3));
        end
        wait_drain();
        rdy_mode = 0;
        begin
            int acc = 0;
            s_vld = 1;
            for (int c = 0; c < 200 && acc < 17; c++) begin
                @(negedge clk);
                if (s_rdy) acc++;
            end
            tick(1);
            s_vld = 0;
            chk("small_accepts", 64'(acc), 17);
            tick(3);
            chk("pkt_cnt_wrap", 64'(s_pkt), 1);
        end
        for (int k = 1; k <= 16; k++) begin
            s_vld = 1;
            tick(1);
            s_vld = 0;
            s_clr = 1;
            tick(1);
            s_clr = 0;
            chk("abort_sat", 64'(s_abort), 64'(k < 15 ? k : 15));
        end
        chk("abort_no_pkt", 64'(s_pkt), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pkt_serializer.md
Name: pkt_serializer

Overview:
- Downstream neighbour of package_gen. Consumes one complete packet of NUM_WORDS parallel 36-bit words (pkt_gen_data_0..23, flattened) under a valid/ready handshake.
- Replays the packet as a beat-per-cycle stream with sop/eop markers toward the capture output FIFO / link interface.
- Holds a full one-packet buffer, so package_gen can be released as soon as the packet is latched.

Parameters:
- NUM_WORDS, 24, words per packet (must be ≥2).
- DW, 36, bits per word.
- CNT_W, 16, width of the packet and abort status counters.

Ports:
- clk  input  1  block clock.
- rst_n  input  1  asynchronous active-low reset.
- soft_clr  input  1  synchronous clear: abort the current packet, return to IDLE.
- pkt_in_data  input  NUM_WORDS*DW  packet words; word i at [i*DW +: DW] (word 0 = pkt_gen_data_0).
- pkt_in_vld  input  1  packet present on pkt_in_data.
- pkt_in_rdy  output  1  block can accept a packet this cycle.
- out_data  output  DW  current beat.
- out_vld  output  1  out_data valid.
- out_sop  output  1  first beat of packet.
- out_eop  output  1  last beat of packet.
- out_rdy  input  1  downstream accepts the beat.
- pkt_cnt  output  CNT_W  packets fully sent; wraps.
- abort_cnt  output  CNT_W  packets truncated by soft_clr; saturates.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state=IDLE, idx=0, buffer=0, out_vld=0, out_sop=0, out_eop=0, out_data=0, pkt_cnt=0, abort_cnt=0. pkt_in_rdy=1 once reset is released.
- FSM states: IDLE, SEND.
- IDLE:
  - pkt_in_rdy=1, out_vld=0.
  - On pkt_in_vld: latch all NUM_WORDS words into the buffer, idx←0, go to SEND.
  - First beat appears on the cycle after acceptance (latency 1).
- SEND:
  - Outputs: out_vld=1, out_data=buf[idx], out_sop=(idx==0), out_eop=(idx==NUM_WORDS-1). All are registered and decoded from idx/buffer.
  - Beat transfers when out_vld & out_rdy. On transfer with idx<last: idx←idx+1.
  - While out_rdy=0, out_data, out_sop and out_eop stay stable.
  - On transfer of the last beat: pkt_cnt←pkt_cnt+1 (wraps at 2^CNT_W).
    - If pkt_in_vld is high the same cycle, latch the new packet, idx←0, stay in SEND. This gives zero-bubble back-to-back packets.
    - Otherwise go to IDLE.
- pkt_in_rdy = (state==IDLE) | (state==SEND & idx==NUM_WORDS-1 & out_rdy). This is the only combinational path from out_rdy; it is documented and intentional.
- Buffer is written only on a pkt_in_vld & pkt_in_rdy handshake. pkt_in_data changing at any other time has no effect.
- soft_clr (highest priority):
  - Next state IDLE, idx←0, out_vld←0 on the following cycle.
  - If state was SEND, abort_cnt increments (saturates at all-ones) even if a beat transfers that same cycle; pkt_cnt does not increment.
  - pkt_in_rdy=0 in any cycle where soft_clr=1, so no packet is latched.
- rst_n asserted mid-packet: immediate return to reset values; the partial packet is lost and not counted.
- idx width is clog2(NUM_WORDS); idx never exceeds NUM_WORDS-1.
- Throughput: one beat per cycle with out_rdy held high; NUM_WORDS cycles per packet.

Test Plan:
- Single packet, word i=36'h0_0000_0000+i, out_rdy=1 → 24 beats on consecutive cycles starting 1 cycle after handshake; out_sop on beat 0 only, out_eop on beat 23 only; pkt_cnt=1; back to IDLE.
- Back-to-back: pkt_in_vld held high with two packets (base 36'hA00, 36'hB00), out_rdy=1 → 48 contiguous beats, no idle cycle; second packet latched on the beat-23 cycle; pkt_cnt=2.
- Backpressure: out_rdy toggled 1,0,0,1 repeating → each beat held stable while out_rdy=0; no beat skipped or repeated; order 0..23 preserved.
- soft_clr pulsed at idx=10 → out_vld=0 next cycle, abort_cnt=1, pkt_cnt unchanged; next packet starts at word 0 with out_sop=1.
- rst_n low at idx=5 → all outputs 0 asynchronously; after release, a fresh packet streams correctly and pkt_cnt counts from 0.
- Counter boundaries: 65536 packets → pkt_cnt wraps to 0; force 65535 aborts plus one more → abort_cnt stays at 16'hFFFF.
